// File: rtl/inst_loader.sv
// inst_loader: fills an instruction memory with 9-bit machine-code words taken
// from an 8-bit byte stream. Each word takes two bytes: the low byte supplies
// bits [7:0], bit 0 of the high byte supplies bit 8 (the other high-byte bits
// are dropped). Words are written to consecutive addresses starting at 0.
//
// Ports
//   Clk      : system clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   Start    : load request, only looked at while idle
//   Len      : number of words to load (A+1 bits), captured with Start
//   InByte   : byte stream data
//   InValid  : InByte is valid
//   InReady  : loader accepts a byte this cycle
//   WrEn     : one-cycle instruction memory write strobe
//   WrAddr   : instruction memory write address
//   WrData   : instruction word being written
//   Busy     : load in progress (holds the CPU off)
//   Done     : one-cycle pulse when a load completes
//   Err      : one-cycle pulse when Start is rejected (Len too large)
//
// State table
//   S_IDLE  | waiting for Start
//   S_LO    | waiting for the low byte of the current word
//   S_HI    | waiting for the high byte of the current word
//   S_WRITE | write strobe for the assembled word
//   S_FIN   | Done pulse, then back to idle
module inst_loader #(
  parameter int A = 10,
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [A:0]   Len,
  input  logic [7:0]   InByte,
  input  logic         InValid,
  output logic         InReady,
  output logic         WrEn,
  output logic [A-1:0] WrAddr,
  output logic [W-1:0] WrData,
  output logic         Busy,
  output logic         Done,
  output logic         Err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [A:0] LEN_MAX = (A+1)'(1) << A;

  state_t     state, state_nxt;
  logic [A:0] len_q;
  logic [A:0] cnt;
  logic [A:0] cnt_inc;
  logic       xfer;
  logic       load;
  logic       err_nxt;

  // InReady is registered and is high exactly in S_LO/S_HI, so it doubles
  // as the "this state accepts bytes" qualifier.
  assign xfer    = InValid & InReady;
  assign cnt_inc = cnt + (A+1)'(1);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Start) begin
          if (Len == '0) begin
            state_nxt = S_FIN;
          end else if (Len > LEN_MAX) begin
            err_nxt = 1'b1;
          end else begin
            load      = 1'b1;
            state_nxt = S_LO;
          end
        end
      end
      S_LO:    if (xfer) state_nxt = S_HI;
      S_HI:    if (xfer) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (cnt_inc == len_q) ? S_FIN : S_LO;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      len_q   <= '0;
      cnt     <= '0;
      InReady <= 1'b0;
      WrEn    <= 1'b0;
      WrAddr  <= '0;
      WrData  <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      // Status outputs are decoded from the next state so they line up
      // with the state register and come straight out of flops.
      InReady <= (state_nxt == S_LO) || (state_nxt == S_HI);
      WrEn    <= (state_nxt == S_WRITE);
      Busy    <= (state_nxt != S_IDLE);
      Done    <= (state_nxt == S_FIN);
      Err     <= err_nxt;

      if (load) begin
        len_q  <= Len;
        cnt    <= '0;
        WrAddr <= '0;
      end

      if (state == S_LO && xfer) WrData[7:0] <= InByte;
      if (state == S_HI && xfer) WrData[W-1] <= InByte[0];

      // WrAddr wraps to 0 naturally after the last word of a full-depth load.
      if (state == S_WRITE) begin
        cnt    <= cnt_inc;
        WrAddr <= WrAddr + A'(1);
      end
    end
  end

endmodule
